// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-division steps on
// operand magnitudes, with the sign correction folded into the edge that enters DONE.
module muldiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        kill,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_value,
   input  logic [31:0] rs2_value,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  result_rd,
   output logic        regwrite
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_reg;
   logic [4:0]  count_reg;
   logic [63:0] acc_reg;
   logic [31:0] op_reg;
   logic [2:0]  funct3_reg;
   logic [4:0]  rd_reg;
   logic        sign_a_reg;
   logic        sign_b_reg;
   logic        div_zero_reg;
   logic [31:0] result_reg;
   logic [4:0]  result_rd_reg;
   logic        done_reg;
   logic        busy_reg;

   logic        a_signed;
   logic        b_signed;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   // Operand decode at capture time: signedness per opcode, then magnitudes.
   always_comb begin
      a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
      b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      sign_a   = a_signed & rs1_value[31];
      sign_b   = b_signed & rs2_value[31];
      a_mag    = sign_a ? (32'd0 - rs1_value) : rs1_value;
      b_mag    = sign_b ? (32'd0 - rs2_value) : rs2_value;
   end

   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_sub;
   logic [63:0] acc_next;
   logic [63:0] prod;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] final_value;

   // acc_reg holds {product high, multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, op_reg} : 33'd0);
      div_shift = {acc_reg[63:32], acc_reg[31]};
      div_ge    = div_shift >= {1'b0, op_reg};
      div_sub   = div_shift[31:0] - op_reg;
      if (funct3_reg[2]) begin
         if (div_ge)
            acc_next = {div_sub, acc_reg[30:0], 1'b1};
         else
            acc_next = {div_shift[31:0], acc_reg[30:0], 1'b0};
      end else begin
         acc_next = {mul_sum, acc_reg[31:1]};
      end

      prod = (sign_a_reg ^ sign_b_reg) ? (64'd0 - acc_next) : acc_next;
      // A zero divisor must yield all-ones regardless of dividend sign.
      quot = ((sign_a_reg ^ sign_b_reg) && !div_zero_reg) ? (32'd0 - acc_next[31:0])
                                                           : acc_next[31:0];
      rem  = sign_a_reg ? (32'd0 - acc_next[63:32]) : acc_next[63:32];

      case (funct3_reg)
         3'b000:                 final_value = prod[31:0];
         3'b001, 3'b010, 3'b011: final_value = prod[63:32];
         3'b100, 3'b101:         final_value = quot;
         default:                final_value = rem;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         count_reg     <= 5'd0;
         acc_reg       <= 64'd0;
         op_reg        <= 32'd0;
         funct3_reg    <= 3'd0;
         rd_reg        <= 5'd0;
         sign_a_reg    <= 1'b0;
         sign_b_reg    <= 1'b0;
         div_zero_reg  <= 1'b0;
         result_reg    <= 32'd0;
         result_rd_reg <= 5'd0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && !kill) begin
                  state_reg    <= CALC;
                  busy_reg     <= 1'b1;
                  count_reg    <= 5'd0;
                  funct3_reg   <= funct3;
                  rd_reg       <= rd;
                  sign_a_reg   <= sign_a;
                  sign_b_reg   <= sign_b;
                  div_zero_reg <= (rs2_value == 32'd0);
                  op_reg       <= funct3[2] ? b_mag : a_mag;
                  acc_reg      <= {32'd0, (funct3[2] ? a_mag : b_mag)};
               end
            end
            CALC: begin
               if (kill) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  acc_reg   <= acc_next;
                  count_reg <= count_reg + 5'd1;
                  if (count_reg == 5'd31) begin
                     state_reg     <= DONE;
                     done_reg      <= 1'b1;
                     result_reg    <= final_value;
                     result_rd_reg <= rd_reg;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign result    = result_reg;
   assign result_rd = result_rd_reg;
   assign regwrite  = done_reg & (result_rd_reg != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner vectors, control scenarios and
// randomized back-to-back operations checked against a plain-arithmetic model.
module tb_muldiv_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic        kill;
   logic [2:0]  funct3;
   logic [31:0] rs1_value;
   logic [31:0] rs2_value;
   logic [4:0]  rd;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  result_rd;
   logic        regwrite;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .kill      (kill),
      .funct3    (funct3),
      .rs1_value (rs1_value),
      .rs2_value (rs2_value),
      .rd        (rd),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .result_rd (result_rd),
      .regwrite  (regwrite)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  r;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12] = '{
      '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB},
      '{3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000},
      '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF},
      '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE},
      '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD},
      '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF},
      '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14},
      '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2},
      '{3'd5, 32'h12345678, 32'd0,        5'd9,  32'hFFFFFFFF},
      '{3'd6, 32'h12345678, 32'd0,        5'd10, 32'h12345678},
      '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000},
      '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000}
   };

   // Reference: RV32M semantics using 64-bit integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] m;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      m  = 32'd0;
      case (f3)
         3'd0: begin p = sa * sb; m = p[31:0]; end
         3'd1: begin p = sa * sb; m = p[63:32]; end
         3'd2: begin p = sa * ub; m = p[63:32]; end
         3'd3: begin p = ua * ub; m = p[63:32]; end
         3'd4: if (b == 32'd0) m = 32'hFFFFFFFF; else begin p = sa / sb; m = p[31:0]; end
         3'd5: m = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
         3'd6: if (b == 32'd0) m = a; else begin p = sa % sb; m = p[31:0]; end
         default: m = (b == 32'd0) ? a : a % b;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Issues one op starting in the current cycle and reports what came back; caller compares.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output int lat, output logic [31:0] res,
                         output logic [4:0] rrd, output logic rw, output logic busy_after);
      funct3 = f3; rs1_value = a; rs2_value = b; rd = r; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      funct3 = 3'($urandom); rs1_value = $urandom; rs2_value = $urandom; rd = 5'($urandom);
      lat = -1; res = 32'd0; rrd = 5'd0; rw = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done === 1'b1) begin
            lat = c; res = result; rrd = result_rd; rw = regwrite;
            break;
         end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      busy_after = busy;
      $display("op f3=%0d a=%h b=%h rd=%0d -> result=%h result_rd=%0d regwrite=%0b latency=%0d",
               f3, a, b, r, res, rrd, rw, lat);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b expected 0", regwrite); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      n_checks++; if (result_rd !== 5'd0) begin n_fail++; $display("FAIL reset_result_rd: got %0d expected 0", result_rd); end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_directed();
      int lat; logic [31:0] res; logic [4:0] rrd; logic rw, ba;
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].r, lat, res, rrd, rw, ba);
         n_checks++; if (lat != 33) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); end
         n_checks++; if (res !== vecs[i].exp) begin n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, res, vecs[i].exp); end
         n_checks++; if (rrd !== vecs[i].r) begin n_fail++; $display("FAIL dir%0d_result_rd: got %0d expected %0d", i, rrd, vecs[i].r); end
         n_checks++; if (rw !== 1'b1) begin n_fail++; $display("FAIL dir%0d_regwrite: got %b expected 1", i, rw); end
         n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_after: got %b expected 0", i, ba); end
      end
   endtask

   task automatic test_rd_zero();
      int lat; logic [31:0] res; logic [4:0] rrd; logic rw, ba;
      run_op(3'd0, 32'd6, 32'd7, 5'd0, lat, res, rrd, rw, ba);
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rd0_latency: got %0d expected 33", lat); end
      n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL rd0_result: got %h expected %h", res, 32'd42); end
      n_checks++; if (rw !== 1'b0) begin n_fail++; $display("FAIL rd0_regwrite: got %b expected 0", rw); end
   endtask

   task automatic test_start_while_busy();
      int lat; logic [31:0] res; logic [4:0] rrd;
      funct3 = 3'd5; rs1_value = 32'd1000; rs2_value = 32'd10; rd = 5'd3; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1; res = 32'd0; rrd = 5'd0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) begin
            start = 1'b1; funct3 = 3'd0; rs1_value = 32'd5; rs2_value = 32'd5; rd = 5'd9;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin lat = c; res = result; rrd = result_rd; break; end
         @(posedge clock); #1;
      end
      start = 1'b0;
      $display("op start-while-busy DIVU 1000/10 rd=3 -> result=%h result_rd=%0d latency=%0d", res, rrd, lat);
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL swb_latency: got %0d expected 33", lat); end
      n_checks++; if (res !== 32'd100) begin n_fail++; $display("FAIL swb_result: got %h expected %h", res, 32'd100); end
      n_checks++; if (rrd !== 5'd3) begin n_fail++; $display("FAIL swb_result_rd: got %0d expected 3", rrd); end
      @(posedge clock); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_kill();
      int lat, dones; logic [31:0] res; logic [4:0] rrd; logic rw, ba;
      run_op(3'd0, 32'd2, 32'd3, 5'd4, lat, res, rrd, rw, ba);
      n_checks++; if (res !== 32'd6) begin n_fail++; $display("FAIL kill_base_result: got %h expected %h", res, 32'd6); end
      funct3 = 3'd5; rs1_value = 32'd100; rs2_value = 32'd5; rd = 5'd8; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      kill = 1'b1;
      @(posedge clock); #1;
      kill = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b expected 0", busy); end
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1 || regwrite === 1'b1) dones++;
         @(posedge clock); #1;
      end
      $display("op killed DIVU 100/5 rd=8 -> done pulses=%0d result=%h result_rd=%0d", dones, result, result_rd);
      n_checks++; if (dones != 0) begin n_fail++; $display("FAIL kill_no_done: got %0d pulses expected 0", dones); end
      n_checks++; if (result !== 32'd6) begin n_fail++; $display("FAIL kill_result_held: got %h expected %h", result, 32'd6); end
      n_checks++; if (result_rd !== 5'd4) begin n_fail++; $display("FAIL kill_rd_held: got %0d expected 4", result_rd); end
   endtask

   task automatic test_start_kill_idle();
      int dones;
      funct3 = 3'd0; rs1_value = 32'd9; rs2_value = 32'd9; rd = 5'd20; start = 1'b1; kill = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; kill = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL skidle_busy: got %b expected 0", busy); end
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) dones++;
         @(posedge clock); #1;
      end
      $display("op start+kill MUL 9*9 rd=20 -> done pulses=%0d result=%h", dones, result);
      n_checks++; if (dones != 0) begin n_fail++; $display("FAIL skidle_no_done: got %0d pulses expected 0", dones); end
      n_checks++; if (result !== 32'd6) begin n_fail++; $display("FAIL skidle_result_held: got %h expected %h", result, 32'd6); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] res; logic [4:0] rrd; logic rw, ba;
      funct3 = 3'd0; rs1_value = 32'h1234; rs2_value = 32'd5; rd = 5'd17; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (19) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b expected 0", done); end
      n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL rmid_regwrite: got %b expected 0", regwrite); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rmid_result: got %h expected 0", result); end
      n_checks++; if (result_rd !== 5'd0) begin n_fail++; $display("FAIL rmid_result_rd: got %0d expected 0", result_rd); end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      run_op(3'd0, 32'd3, 32'd4, 5'd7, lat, res, rrd, rw, ba);
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rmid_mul_latency: got %0d expected 33", lat); end
      n_checks++; if (res !== 32'd12) begin n_fail++; $display("FAIL rmid_mul_result: got %h expected %h", res, 32'd12); end
      n_checks++; if (rrd !== 5'd7) begin n_fail++; $display("FAIL rmid_mul_rd: got %0d expected 7", rrd); end
   endtask

   task automatic test_back_to_back_random();
      int lat; logic [31:0] res, a, b, exp; logic [4:0] rrd, r; logic [2:0] f3; logic rw, ba;
      for (int i = 0; i < 48; i++) begin
         f3  = 3'($urandom_range(0, 7));
         a   = pick_operand();
         b   = pick_operand();
         r   = 5'($urandom_range(0, 31));
         exp = model(f3, a, b);
         run_op(f3, a, b, r, lat, res, rrd, rw, ba);
         n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected 33", i, lat); end
         n_checks++; if (res !== exp) begin n_fail++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, res, exp); end
         n_checks++; if (rrd !== r) begin n_fail++; $display("FAIL rnd%0d_result_rd: got %0d expected %0d", i, rrd, r); end
         n_checks++; if (rw !== (r != 5'd0)) begin n_fail++; $display("FAIL rnd%0d_regwrite: got %b expected %b", i, rw, (r != 5'd0)); end
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; kill = 1'b0;
      funct3 = 3'd0; rs1_value = 32'd0; rs2_value = 32'd0; rd = 5'd0;
      test_reset();
      test_directed();
      test_rd_zero();
      test_start_while_busy();
      test_kill();
      test_start_kill_idle();
      test_reset_mid();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. Consumes the two source operands read from the register file plus destination index, computes one of the eight RV32M operations over a fixed multi-cycle latency, and presents result, destination index and write enable for the register-file write port. The pipeline holds the instruction while `busy` is high.

## Interface
- No parameters; fixed XLEN = 32.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `kill` in 1: abort the in-flight operation (pipeline flush).
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_value` in 32: operand A (multiplicand / dividend).
- `rs2_value` in 32: operand B (multiplier / divisor).
- `rd` in 5: destination register index.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; result valid.
- `result` out 32: operation result; holds until next `done`.
- `result_rd` out 5: destination index captured with the operation; held like `result`.
- `regwrite` out 1: `done & (result_rd != 0)`; drives the register-file write enable.

## Operation
- States: IDLE, CALC, DONE. IDLE→CALC on `start & !kill`: latch funct3, rd, operand magnitudes, sign flags; counter = 0. CALC→DONE when counter = 31 after its iteration. DONE→IDLE unconditionally.
- Signed handling: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats A signed, B unsigned; MULHU/DIVU/REMU unsigned. Operate on 32-bit magnitudes, fix sign in DONE.
- Multiply: 32 shift-add iterations into a 64-bit accumulator. MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits of the signed/mixed/unsigned 64-bit product (negate full 64 bits before selecting high half).
- Divide: 32 restoring-division iterations (33-bit partial remainder). Quotient negated if operand signs differ (signed ops); remainder takes dividend's sign.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = rs1_value. No trap.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Special cases do not shortcut: latency is constant for every opcode and operand.
- `start` while `busy`: ignored, no state change.
- `kill` in CALC or DONE: next edge → IDLE, `done`/`regwrite` not asserted, `result`/`result_rd` keep previous values. `kill` with `start` in IDLE: kill wins, nothing captured.
- Reset (any state): state IDLE, counter 0, `busy`=0, `done`=0, `regwrite`=0, `result`=0, `result_rd`=0, internal datapath registers 0.

## Timing
- `start` high in cycle T (captured at the edge closing T) → `busy` high cycles T+1 … T+33 → `done`, `regwrite`, new `result`/`result_rd` presented in cycle T+33 (DONE state).
- `result`/`result_rd` registered, updated on the edge entering DONE, stable until next DONE entry.
- Earliest next accepted `start`: cycle T+34.
- All outputs glitch-free registers except `regwrite` (AND of two registered values).
- Reset deassertion is synchronised by the top level; the block only requires async assertion.

## Test plan
- MUL: rs1=7, rs2=0xFFFFFFFD (−3), rd=5, start in T → `done`=1 in T+33, result=0xFFFFFFEB, result_rd=5, regwrite=1; busy low in T+34.
- High products: MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide: DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- Corners: DIVU 0x12345678/0 → 0xFFFFFFFF; REM 0x12345678/0 → 0x12345678; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; all at T+33.
- Control: start with rd=0 → done pulses, regwrite=0; start re-asserted at T+5 while busy → ignored; kill at T+10 → busy=0 in T+11, no done, result unchanged; start+kill in IDLE → no capture.
- Reset low mid-CALC (T+20) → busy, done, regwrite, result, result_rd all 0 immediately; after release, fresh MUL 3×4 → 12 at its T+33.
